// File: rtl/lea_pkg.sv
// Package lea_pkg: LEA shared width constants, packer FSM state type and lane helper.
// Shared with the LEA block register stage.
// Configuration macro: LEA_PACK_BSWAP_EN (defined -> big-endian input byte ordering).
package lea_pkg;

  localparam int unsigned LEA_BYTE_W      = 8;
  localparam int unsigned LEA_WORD_W      = 32;
  localparam int unsigned LEA_BLOCK_WORDS = 4;
  localparam int unsigned LEA_WORD_BYTES  = LEA_WORD_W / LEA_BYTE_W;
  localparam int unsigned LEA_BCNT_W      = $clog2(LEA_WORD_BYTES);

  typedef enum logic [0:0] {
    PK_FILL = 1'b0,
    PK_HOLD = 1'b1
  } pk_state_t;

  // Map the k-th received byte of a word to its physical byte lane in the word.
  function automatic logic [LEA_BCNT_W-1:0] lea_lane(input logic [LEA_BCNT_W-1:0] k);
`ifdef LEA_PACK_BSWAP_EN
    return LEA_BCNT_W'(LEA_WORD_BYTES - 1) - k;
`else
    return k;
`endif
  endfunction

endpackage

// File: rtl/lea_word_packer.sv
// lea_word_packer: collects a valid/ready byte stream into 32-bit LEA words and frames them
// into blocks of WORDS_PER_BLOCK words. Each finished word is held on m_data with m_valid
// until m_ready; m_ce is the one-cycle write strobe for the downstream block register.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   s_valid/s_ready       input byte handshake
//   s_data, s_first       input byte; s_first marks byte 0 of word 0 of a new block
//   m_valid/m_ready       output word handshake
//   m_data                assembled word
//   m_ce                  m_valid & m_ready
//   m_word_idx, m_last    word position in block, last-word flag
//   err_sync              sticky: s_first seen mid-word or mid-block
//
// Configuration macro: LEA_PACK_BSWAP_EN (lane order handled by lea_pkg::lea_lane).
module lea_word_packer
  import lea_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = LEA_BLOCK_WORDS,
  parameter int unsigned IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [LEA_BYTE_W-1:0] s_data,
  input  logic                  s_first,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [LEA_WORD_W-1:0] m_data,
  output logic                  m_ce,
  output logic [IDX_W-1:0]      m_word_idx,
  output logic                  m_last,
  output logic                  err_sync
);

  pk_state_t             state_q, state_d;
  logic [LEA_BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0]      word_idx_q, word_idx_d;
  logic [LEA_WORD_W-1:0] data_q, data_d;
  logic                  err_q, err_d;

  logic                  in_hs, out_hs;
  logic [LEA_BCNT_W-1:0] eff_cnt, lane;
  logic [IDX_W-1:0]      eff_idx;

  assign m_valid    = (state_q == PK_HOLD);
  // In HOLD a byte may only enter in the cycle the held word leaves, so there is no bubble.
  assign s_ready    = ~rst & ((state_q == PK_FILL) | m_ready);
  assign m_ce       = m_valid & m_ready;
  assign m_data     = data_q;
  assign m_word_idx = word_idx_q;
  assign m_last     = (word_idx_q == IDX_W'(WORDS_PER_BLOCK - 1));
  assign err_sync   = err_q;

  assign in_hs  = s_valid & s_ready;
  assign out_hs = m_ce;

  always_comb begin
    // Effective position as seen by an incoming byte, after any coincident output handshake.
    eff_idx = out_hs ? word_idx_q + IDX_W'(1) : word_idx_q;
    eff_cnt = (state_q == PK_HOLD) ? '0 : byte_cnt_q;
    lane    = s_first ? '0 : eff_cnt;

    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = eff_idx;
    data_d     = data_q;
    err_d      = err_q;

    if (out_hs) begin
      state_d    = PK_FILL;
      byte_cnt_d = '0;
    end

    if (in_hs) begin
      // Lane-write decoder: only the addressed byte lane is updated.
      for (int k = 0; k < int'(LEA_WORD_BYTES); k++) begin
        if (lea_lane(lane) == LEA_BCNT_W'(k)) begin
          data_d[k*LEA_BYTE_W +: LEA_BYTE_W] = s_data;
        end
      end

      if (s_first) begin
        // Resynchronise: this byte starts word 0; any partial word is abandoned.
        byte_cnt_d = LEA_BCNT_W'(1);
        word_idx_d = '0;
        if ((eff_cnt != '0) || (eff_idx != '0)) begin
          err_d = 1'b1;
        end
      end else if (eff_cnt == LEA_BCNT_W'(LEA_WORD_BYTES - 1)) begin
        state_d    = PK_HOLD;
        byte_cnt_d = '0;
      end else begin
        byte_cnt_d = eff_cnt + LEA_BCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PK_FILL;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_lea_word_packer.sv
// tb_lea_word_packer: directed and randomized bench for lea_word_packer. Expected words come
// from a byte-queue framing model (bytes in, words with block positions out).
module tb_lea_word_packer;

  localparam int WPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h00;
  logic        s_first = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_ce;
  logic [1:0]  m_word_idx;
  logic        m_last;
  logic        err_sync;

  lea_word_packer #(
    .WORDS_PER_BLOCK(WPB),
    .IDX_W          (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_first   (s_first),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_ce      (m_ce),
    .m_word_idx(m_word_idx),
    .m_last    (m_last),
    .err_sync  (err_sync)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int          idx;
  } exp_word_t;

  logic [7:0]  cur[$];
  exp_word_t   expq[$];
  int          pos = 0;
  logic        exp_err = 1'b0;
  int          ce_cnt = 0;
  int          last_cnt = 0;
  logic        acc = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] stall_data;
  logic [1:0]  stall_idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // Framing model: bytes accumulate until four are present, then form one word.
  task automatic model_accept(input logic [7:0] d, input logic f);
    logic [31:0] w;
    if (f) begin
      if (cur.size() != 0 || pos != 0) exp_err = 1'b1;
      cur.delete();
      pos = 0;
    end
    cur.push_back(d);
    if (cur.size() == 4) begin
      w = '0;
      for (int k = 0; k < 4; k++) begin
`ifdef LEA_PACK_BSWAP_EN
        w = w | (32'(cur[k]) << (8 * (3 - k)));
`else
        w = w | (32'(cur[k]) << (8 * k));
`endif
      end
      expq.push_back('{data: w, idx: pos});
      pos = (pos + 1) % WPB;
      cur.delete();
    end
  endtask

  task automatic monitor();
    exp_word_t w;
    acc = 1'b0;
    if (rst) begin
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_ce", m_ce, 0);
      chk("rst_m_word_idx", m_word_idx, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_err_sync", err_sync, 0);
      stall = 1'b0;
    end else begin
      chk("m_ce_strobe", m_ce, m_valid && m_ready);
      chk("err_sync", err_sync, exp_err);
      if (stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, stall_data);
        chk("hold_idx", m_word_idx, stall_idx);
      end
      stall      = m_valid && !m_ready;
      stall_data = m_data;
      stall_idx  = m_word_idx;
      if (m_ce) begin
        ce_cnt++;
        if (m_last) last_cnt++;
        chk("word_pending", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          w = expq.pop_front();
          chk("m_data", m_data, w.data);
          chk("m_word_idx", m_word_idx, w.idx);
          chk("m_last", m_last, w.idx == WPB - 1);
        end
      end
      acc = s_valid && s_ready;
      if (acc) model_accept(s_data, s_first);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic f, input logic r);
    s_valid = v;
    s_data  = d;
    s_first = f;
    m_ready = r;
  endtask

  task automatic finish_cycle();
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r);
    drive(v, d, f, r);
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 8'h00, 0, 0);
    cur.delete();
    expq.delete();
    pos     = 0;
    exp_err = 1'b0;
    repeat (2) step(0, 8'h00, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w0;
    logic [7:0]  b;
    int          tries;
    logic        v, r;

    @(posedge clk);
    #1;

    // 1: sixteen bytes with full back-pressure freedom
    do_reset();
    ce_cnt = 0;
    last_cnt = 0;
`ifdef LEA_PACK_BSWAP_EN
    w0 = 32'h10111213;
`else
    w0 = 32'h13121110;
`endif
    for (int i = 0; i < 16; i++) begin
      drive(1, 8'(8'h10 + i), i == 0, 1);
      @(negedge clk);
      chk("no_bubble", s_ready, 1);
      if (i == 4) begin
        chk("t1_first_word", m_data, w0);
        chk("t1_first_idx", m_word_idx, 0);
        chk("t1_first_ce", m_ce, 1);
      end
      finish_cycle();
    end

    // 2: stall the output for five cycles, then release with a byte waiting
    for (int i = 0; i < 4; i++) step(1, 8'(8'h20 + i), i == 0, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'h24, 0, 0);
      @(negedge clk);
      chk("t2_m_valid", m_valid, 1);
      chk("t2_s_ready", s_ready, 0);
      chk("t2_m_ce", m_ce, 0);
      finish_cycle();
    end
    drive(1, 8'h24, 0, 1);
    @(negedge clk);
    chk("t2_release_s_ready", s_ready, 1);
    chk("t2_release_m_ce", m_ce, 1);
    finish_cycle();
    chk("t2_ce_count", ce_cnt, 5);
    chk("t2_last_count", last_cnt, 1);

    // 3: s_first in the middle of a word
    do_reset();
    step(1, 8'hAA, 0, 1);
    step(1, 8'hBB, 0, 1);
    step(1, 8'h01, 1, 1);
    step(1, 8'h02, 0, 1);
    step(1, 8'h03, 0, 1);
    step(1, 8'h04, 0, 1);
    drive(0, 8'h00, 0, 1);
    @(negedge clk);
`ifdef LEA_PACK_BSWAP_EN
    chk("t3_word", m_data, 32'h01020304);
`else
    chk("t3_word", m_data, 32'h04030201);
`endif
    chk("t3_idx", m_word_idx, 0);
    chk("t3_err", err_sync, 1);
    finish_cycle();
    repeat (3) step(0, 8'h00, 0, 1);
    chk("t3_err_sticky", err_sync, 1);

    // 4: reset two bytes into word 2, then a clean block
    do_reset();
    ce_cnt = 0;
    for (int i = 0; i < 10; i++) step(1, 8'(8'h30 + i), i == 0, 1);
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), i == 0, 1);
    repeat (2) step(0, 8'h00, 0, 1);
    chk("t4_ce_count", ce_cnt, 6);
    chk("t4_drained", expq.size(), 0);

`ifdef LEA_PACK_BSWAP_EN
    // 5: byte-swapped lane order
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), i == 0, 1);
    drive(0, 8'h00, 0, 0);
    @(negedge clk);
    chk("t5_bswap_word", m_data, 32'h10111213);
    chk("t5_bswap_idx", m_word_idx, 0);
    finish_cycle();
`endif

    // 6: random valid/ready, 64 blocks
    do_reset();
    ce_cnt = 0;
    last_cnt = 0;
    for (int blk = 0; blk < 64; blk++) begin
      for (int j = 0; j < 16; j++) begin
        b = 8'($urandom);
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 200) begin
          v = ($urandom_range(0, 3) != 0);
          r = ($urandom_range(0, 3) != 0);
          if (v) step(1, b, j == 0, r);
          else   step(0, 8'($urandom), 1'($urandom_range(0, 1)), r);
          tries++;
        end
        chk("t6_byte_accepted", acc, 1);
      end
    end
    for (int i = 0; i < 20 && expq.size() != 0; i++) step(0, 8'h00, 0, 1);
    chk("t6_drained", expq.size(), 0);
    chk("t6_ce_count", ce_cnt, 256);
    chk("t6_last_count", last_cnt, 64);
    chk("t6_err_sync", err_sync, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
